// File: rtl/core_operand_fetch.sv
// Operand-read stage: drives regfile read ports, absorbs the one-cycle read latency,
// forwards writebacks the synchronous read misses and hands operand pairs to execute.
module core_operand_fetch #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [4:0]           dec_rs0_addr_i,
  input  logic [4:0]           dec_rs1_addr_i,
  input  logic [PAYLOAD_W-1:0] dec_payload_i,
  output logic [4:0]           rf_rs0_addr_o,
  output logic [4:0]           rf_rs1_addr_o,
  input  logic [31:0]          rf_rs0_data_i,
  input  logic [31:0]          rf_rs1_data_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [31:0]          wb_data_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [31:0]          ex_rs0_data_o,
  output logic [31:0]          ex_rs1_data_o,
  output logic [PAYLOAD_W-1:0] ex_payload_o
);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_INFLIGHT = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [4:0]           r_rs0_q, r_rs0_d, r_rs1_q, r_rs1_d;
  logic [PAYLOAD_W-1:0] r_payload_q, r_payload_d;
  logic                 byp0_q, byp0_d, byp1_q, byp1_d;
  logic [31:0]          byp0_data_q, byp0_data_d, byp1_data_q, byp1_data_d;
  logic [31:0]          skid0_q, skid0_d, skid1_q, skid1_d;
  logic                 ex_valid_q, ex_valid_d;
  logic [31:0]          ex_rs0_q, ex_rs0_d, ex_rs1_q, ex_rs1_d;
  logic [4:0]           ex_rs0_addr_q, ex_rs0_addr_d, ex_rs1_addr_q, ex_rs1_addr_d;
  logic [PAYLOAD_W-1:0] ex_payload_q, ex_payload_d;
  logic                 o_free_s, accept_s, held_s;
  logic [31:0]          res0_s, res1_s;

  // Priority: x0, live writeback, then held skid value or bypass/regfile data.
  function automatic logic [31:0] resolve(
    input logic [4:0]  rs,
    input logic        held,
    input logic        byp,
    input logic [31:0] byp_data,
    input logic [31:0] rf_data,
    input logic [31:0] skid_data,
    input logic        wb_we,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data
  );
    logic [31:0] r;
    if (rs == 5'd0) begin
      r = 32'd0;
    end else if (wb_we && (wb_addr == rs)) begin
      r = wb_data;
    end else if (held) begin
      r = skid_data;
    end else if (byp) begin
      r = byp_data;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

  function automatic logic wb_hit(
    input logic       wb_we,
    input logic [4:0] wb_addr,
    input logic [4:0] rs
  );
    return wb_we && (wb_addr == rs) && (rs != 5'd0);
  endfunction

  assign rf_rs0_addr_o = dec_rs0_addr_i;
  assign rf_rs1_addr_o = dec_rs1_addr_i;
  assign o_free_s      = !ex_valid_q || ex_ready_i;
  assign dec_ready_o   = (state_q == ST_EMPTY) || o_free_s;
  assign accept_s      = dec_valid_i && dec_ready_o;
  assign held_s        = (state_q == ST_HELD);
  assign res0_s = resolve(r_rs0_q, held_s, byp0_q, byp0_data_q, rf_rs0_data_i, skid0_q,
                          wb_we_i, wb_addr_i, wb_data_i);
  assign res1_s = resolve(r_rs1_q, held_s, byp1_q, byp1_data_q, rf_rs1_data_i, skid1_q,
                          wb_we_i, wb_addr_i, wb_data_i);

  assign ex_valid_o    = ex_valid_q;
  assign ex_rs0_data_o = ex_rs0_q;
  assign ex_rs1_data_o = ex_rs1_q;
  assign ex_payload_o  = ex_payload_q;

  // Next-state: R-stage FSM, output register load/snoop, acceptance capture.
  always_comb begin
    state_d       = state_q;
    r_rs0_d       = r_rs0_q;
    r_rs1_d       = r_rs1_q;
    r_payload_d   = r_payload_q;
    byp0_d        = byp0_q;
    byp1_d        = byp1_q;
    byp0_data_d   = byp0_data_q;
    byp1_data_d   = byp1_data_q;
    skid0_d       = skid0_q;
    skid1_d       = skid1_q;
    ex_valid_d    = ex_valid_q;
    ex_rs0_d      = ex_rs0_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs0_addr_d = ex_rs0_addr_q;
    ex_rs1_addr_d = ex_rs1_addr_q;
    ex_payload_d  = ex_payload_q;

    if (flush_i) begin
      state_d    = ST_EMPTY;
      ex_valid_d = 1'b0;
      byp0_d     = 1'b0;
      byp1_d     = 1'b0;
    end else begin
      // A stalled output keeps tracking writebacks to its source registers.
      if (ex_valid_q && !ex_ready_i) begin
        ex_rs0_d = wb_hit(wb_we_i, wb_addr_i, ex_rs0_addr_q) ? wb_data_i : ex_rs0_q;
        ex_rs1_d = wb_hit(wb_we_i, wb_addr_i, ex_rs1_addr_q) ? wb_data_i : ex_rs1_q;
      end else begin
        ex_valid_d = 1'b0;
      end

      case (state_q)
        ST_EMPTY: begin
          state_d = accept_s ? ST_INFLIGHT : ST_EMPTY;
        end
        ST_INFLIGHT, ST_HELD: begin
          if (o_free_s) begin
            ex_valid_d    = 1'b1;
            ex_rs0_d      = res0_s;
            ex_rs1_d      = res1_s;
            ex_rs0_addr_d = r_rs0_q;
            ex_rs1_addr_d = r_rs1_q;
            ex_payload_d  = r_payload_q;
            state_d       = accept_s ? ST_INFLIGHT : ST_EMPTY;
          end else begin
            skid0_d = res0_s;
            skid1_d = res1_s;
            state_d = ST_HELD;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase

      // The regfile read on this edge returns the pre-write value, so grab the writeback now.
      if (accept_s) begin
        r_rs0_d     = dec_rs0_addr_i;
        r_rs1_d     = dec_rs1_addr_i;
        r_payload_d = dec_payload_i;
        byp0_d      = wb_hit(wb_we_i, wb_addr_i, dec_rs0_addr_i);
        byp1_d      = wb_hit(wb_we_i, wb_addr_i, dec_rs1_addr_i);
        byp0_data_d = wb_data_i;
        byp1_data_d = wb_data_i;
      end else begin
        r_payload_d = r_payload_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_EMPTY;
      r_rs0_q       <= 5'd0;
      r_rs1_q       <= 5'd0;
      r_payload_q   <= '0;
      byp0_q        <= 1'b0;
      byp1_q        <= 1'b0;
      byp0_data_q   <= 32'd0;
      byp1_data_q   <= 32'd0;
      skid0_q       <= 32'd0;
      skid1_q       <= 32'd0;
      ex_valid_q    <= 1'b0;
      ex_rs0_q      <= 32'd0;
      ex_rs1_q      <= 32'd0;
      ex_rs0_addr_q <= 5'd0;
      ex_rs1_addr_q <= 5'd0;
      ex_payload_q  <= '0;
    end else begin
      state_q       <= state_d;
      r_rs0_q       <= r_rs0_d;
      r_rs1_q       <= r_rs1_d;
      r_payload_q   <= r_payload_d;
      byp0_q        <= byp0_d;
      byp1_q        <= byp1_d;
      byp0_data_q   <= byp0_data_d;
      byp1_data_q   <= byp1_data_d;
      skid0_q       <= skid0_d;
      skid1_q       <= skid1_d;
      ex_valid_q    <= ex_valid_d;
      ex_rs0_q      <= ex_rs0_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs0_addr_q <= ex_rs0_addr_d;
      ex_rs1_addr_q <= ex_rs1_addr_d;
      ex_payload_q  <= ex_payload_d;
    end
  end

endmodule

// File: tb/tb_core_operand_fetch.sv
// Bench for core_operand_fetch: behavioural regfile, expected operand pairs queued at
// acceptance and compared against handshaken outputs.
module tb_core_operand_fetch;
  localparam int PW = 32;
  localparam int OW = 64 + PW;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, dec_valid_i, dec_ready_o;
  logic [4:0]    dec_rs0_addr_i, dec_rs1_addr_i, rf_rs0_addr_o, rf_rs1_addr_o;
  logic [PW-1:0] dec_payload_i, ex_payload_o;
  logic [31:0]   rf_rs0_data_i, rf_rs1_data_i, wb_data_i, ex_rs0_data_o, ex_rs1_data_o;
  logic          wb_we_i, ex_valid_o, ex_ready_i;
  logic [4:0]    wb_addr_i;

  logic [31:0]   mem [32];
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] obs_q [$];
  logic [OW-1:0] e, o;
  logic          acc_last;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  core_operand_fetch #(.PAYLOAD_W(PW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs0_addr_i(dec_rs0_addr_i), .dec_rs1_addr_i(dec_rs1_addr_i),
    .dec_payload_i(dec_payload_i),
    .rf_rs0_addr_o(rf_rs0_addr_o), .rf_rs1_addr_o(rf_rs1_addr_o),
    .rf_rs0_data_i(rf_rs0_data_i), .rf_rs1_data_i(rf_rs1_data_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_rs0_data_o(ex_rs0_data_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_payload_o(ex_payload_o)
  );

  // Regfile with registered read: a read on a write edge returns the old value.
  always @(posedge clk) begin
    rf_rs0_data_i <= (rf_rs0_addr_o == 5'd0) ? 32'd0 : mem[rf_rs0_addr_o];
    rf_rs1_data_i <= (rf_rs1_addr_o == 5'd0) ? 32'd0 : mem[rf_rs1_addr_o];
    if (wb_we_i && wb_addr_i != 5'd0) mem[wb_addr_i] <= wb_data_i;
  end

  function automatic logic [31:0] sval(input int r);
    return 32'h1000 + 32'(r) * 32'h111;
  endfunction

  task automatic tick();
    #2;
    acc_last = dec_valid_i && dec_ready_o && !flush_i && !rst_i;
    if (ex_valid_o && ex_ready_i && !flush_i && !rst_i)
      obs_q.push_back({ex_rs0_data_o, ex_rs1_data_o, ex_payload_o});
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1'b1; wb_addr_i = a; wb_data_i = d;
    tick();
    wb_we_i = 1'b0;
  endtask

  task automatic offer(input logic [4:0] a0, input logic [4:0] a1, input logic [PW-1:0] p);
    dec_valid_i = 1'b1; dec_rs0_addr_i = a0; dec_rs1_addr_i = a1; dec_payload_i = p;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; dec_valid_i = 1'b0; ex_ready_i = 1'b1; wb_we_i = 1'b0;
    wb_addr_i = 5'd0; wb_data_i = 32'd0; offer(5'd0, 5'd0, 32'd0); dec_valid_i = 1'b0;
    tick(); tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", ex_valid_o); end
    n_cmp++; if ({ex_rs0_data_o, ex_rs1_data_o} !== 64'd0) begin n_bad++; $display("FAIL rst_data: got %h %h want 0", ex_rs0_data_o, ex_rs1_data_o); end
    n_cmp++; if (ex_payload_o !== 32'd0) begin n_bad++; $display("FAIL rst_payload: got %h want 0", ex_payload_o); end
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", dec_ready_o); end
    rst_i = 1'b0;
    for (int r = 1; r < 32; r++) wr(5'(r), 32'd0);
    obs_q.delete();
  endtask

  task automatic test_basic();
    wr(5'd5, 32'h11); wr(5'd6, 32'h22);
    offer(5'd5, 5'd6, 32'hA);
    tick();
    n_cmp++; if (acc_last !== 1'b1) begin n_bad++; $display("FAIL basic_accept: got %b want 1", acc_last); end
    exp_q.push_back({32'h11, 32'h22, 32'hA});
    dec_valid_i = 1'b0;
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_lat1: got %b want 0", ex_valid_o); end
    tick();
    n_cmp++; if (ex_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_lat2: got %b want 1", ex_valid_o); end
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b want 1", dec_ready_o); end
    for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL basic_out: got nothing want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL basic_out: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_bypass();
    offer(5'd7, 5'd0, 32'hB);
    wb_we_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'hDEAD;
    tick();
    if (acc_last) exp_q.push_back({32'hDEAD, 32'd0, 32'hB});
    dec_valid_i = 1'b0; wb_we_i = 1'b0;
    tick(); tick();
    offer(5'd8, 5'd7, 32'hC);
    tick();
    if (acc_last) exp_q.push_back({32'hDEAD, 32'hDEAD, 32'hC});
    dec_valid_i = 1'b0;
    wb_we_i = 1'b1; wb_addr_i = 5'd8; wb_data_i = 32'hDEAD;
    tick();
    wb_we_i = 1'b0;
    tick();
    offer(5'd0, 5'd0, 32'hD);
    wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF;
    tick();
    if (acc_last) exp_q.push_back({32'd0, 32'd0, 32'hD});
    dec_valid_i = 1'b0;
    tick();
    wb_we_i = 1'b0;
    n_cmp++; if (exp_q.size() != 3) begin n_bad++; $display("FAIL byp_accepts: got %0d want 3", exp_q.size()); end
    for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL byp_out: got nothing want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL byp_out: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_stall_held();
    wr(5'd9, 32'h90); wr(5'd10, 32'h10A);
    ex_ready_i = 1'b0;
    offer(5'd5, 5'd6, 32'h1);
    tick();
    if (acc_last) exp_q.push_back({32'h11, 32'h22, 32'h1});
    offer(5'd9, 5'd10, 32'h2);
    tick();
    if (acc_last) exp_q.push_back({32'h99, 32'h10A, 32'h2});
    dec_valid_i = 1'b0;
    tick();
    n_cmp++; if (dec_ready_o !== 1'b0) begin n_bad++; $display("FAIL held_ready: got %b want 0", dec_ready_o); end
    n_cmp++; if (ex_valid_o !== 1'b1) begin n_bad++; $display("FAIL held_valid: got %b want 1", ex_valid_o); end
    wr(5'd9, 32'h99);
    tick(); tick();
    n_cmp++; if (ex_rs0_data_o !== 32'h11) begin n_bad++; $display("FAIL held_stable: got %h want 11", ex_rs0_data_o); end
    n_cmp++; if (exp_q.size() != 2) begin n_bad++; $display("FAIL held_accepts: got %0d want 2", exp_q.size()); end
    ex_ready_i = 1'b1;
    for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) tick();
    tick(); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL held_out: got nothing want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL held_out: got %h want %h", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL held_dup: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    for (int r = 11; r <= 18; r++) wr(5'(r), sval(r));
    ex_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(5'(11 + i), 5'(18 - i), 32'h100 + 32'(i));
      tick();
      n_cmp++; if (acc_last !== 1'b1) begin n_bad++; $display("FAIL stream_accept%0d: got %b want 1", i, acc_last); end
      exp_q.push_back({sval(11 + i), sval(18 - i), 32'h100 + 32'(i)});
    end
    dec_valid_i = 1'b0;
    tick(); tick();
    n_cmp++; if (obs_q.size() != 8) begin n_bad++; $display("FAIL stream_rate: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL stream_out: got nothing want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL stream_out: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_flush_reset();
    ex_ready_i = 1'b0;
    offer(5'd5, 5'd6, 32'h21); tick();
    offer(5'd9, 5'd10, 32'h22); tick();
    dec_valid_i = 1'b0; tick();
    flush_i = 1'b1; offer(5'd5, 5'd5, 32'hF);
    tick();
    flush_i = 1'b0; dec_valid_i = 1'b0;
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", ex_valid_o); end
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b want 1", dec_ready_o); end
    ex_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL flush_leak: got %0d outputs want 0", obs_q.size()); end
    offer(5'd5, 5'd6, 32'h33); tick();
    offer(5'd9, 5'd6, 32'h34); tick();
    rst_i = 1'b1; tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b want 0", ex_valid_o); end
    n_cmp++; if ({ex_rs0_data_o, ex_rs1_data_o} !== 64'd0) begin n_bad++; $display("FAIL mrst_data: got %h %h want 0", ex_rs0_data_o, ex_rs1_data_o); end
    n_cmp++; if (ex_payload_o !== 32'd0) begin n_bad++; $display("FAIL mrst_payload: got %h want 0", ex_payload_o); end
    rst_i = 1'b0; dec_valid_i = 1'b0;
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_bad++; $display("FAIL mrst_after: got %b want 0", ex_valid_o); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_stall_held();
    test_back_to_back();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end
endmodule
